cp0_regfile: RTL and testbench

//  Coprocessor-0 register file and exception sequencer for the 5-stage MIPS core. Holds Status(12),

---
 rtl/cp0_regfile.sv | 172 +++++++++++++++++
 tb/tb_cp0_regfile.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// cp0_regfile -- Coprocessor-0 register file and exception sequencer.
//
// Holds Status (12,0), Cause (13,0) and EPC (14,0). Commits MTC0 / SYSCALL /
// ERET from WB, samples external interrupts and issues a registered
// one-cycle redirect (exc_req / exc_pc) to EXC_VECTOR.
//
// Optional feature macro: CP0_TIMER_EN
//   defined   : Count (9,0) free-runs, Compare (11,0) writable, timer
//               interrupt in Cause[30] TI and ORed into IP7 (Cause[15]).
//   undefined : regs 9/11 read 0, writes dropped, TI = 0.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   wb_valid/wb_cp0Op/wb_cs/wb_sel/wb_wdata/wb_pc   committing WB instruction
//   rd_cs/rd_sel -> rd_data    MFC0 read port (combinational, WB bypassed)
//   cp0Forward/ex_wdata/mem_wdata -> epc_out        ERET target to ID
//   int_in                     level-sensitive external interrupt lines
//   exc_req/exc_pc             registered redirect pulse and target
module cp0_regfile #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0800,
  parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [2:0]  wb_cp0Op,
  input  logic [4:0]  wb_cs,
  input  logic [2:0]  wb_sel,
  input  logic [31:0] wb_wdata,
  input  logic [31:0] wb_pc,
  input  logic [4:0]  rd_cs,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data,
  input  logic [1:0]  cp0Forward,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] mem_wdata,
  output logic [31:0] epc_out,
  input  logic [5:0]  int_in,
  output logic        exc_req,
  output logic [31:0] exc_pc
);
  localparam logic [2:0]  OP_MTC0    = 3'b010;
  localparam logic [2:0]  OP_SYSCALL = 3'b011;
  localparam logic [2:0]  OP_ERET    = 3'b100;
  localparam logic [7:0]  A_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0]  A_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0]  A_EPC      = {5'd14, 3'd0};
`ifdef CP0_TIMER_EN
  localparam logic [7:0]  A_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0]  A_COMPARE  = {5'd11, 3'd0};
`endif
  localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;  // IM, EXL, IE
  localparam logic [31:0] CAUSE_MASK  = 32'h0000_0300;  // soft IP1..0

  logic [31:0] status_q, epc_q, cause_val;
  logic [5:0]  ip_q;
  logic [1:0]  sw_ip_q;
  logic [4:0]  exc_code_q;
  logic        ti, ip7;
  logic [7:0]  wb_addr, rd_addr;
  logic        wr_hit, is_sys, is_eret, int_pend, take_int, do_mtc0;
  logic [31:0] rd_reg, rd_mask;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, compare_q, count_nxt;
  logic        ti_q;
  assign ti = ti_q;
`else
  assign ti = 1'b0;
`endif

  assign ip7       = ip_q[5] | ti;
  assign cause_val = {1'b0, ti, 14'd0, ip7, ip_q[4:0], sw_ip_q, 1'b0, exc_code_q, 2'b00};

  assign wb_addr  = {wb_cs, wb_sel};
  assign rd_addr  = {rd_cs, rd_sel};
  assign wr_hit   = wb_valid && (wb_cp0Op == OP_MTC0);
  assign is_sys   = wb_valid && (wb_cp0Op == OP_SYSCALL);
  assign is_eret  = wb_valid && (wb_cp0Op == OP_ERET);
  // Interrupt uses the registered IP bits, so int_in takes one cycle to be seen.
  assign int_pend = (|(cause_val[15:8] & status_q[15:8])) & status_q[0] & ~status_q[1];
  assign take_int = wb_valid && !is_sys && !is_eret && int_pend;
  // An interrupted MTC0 re-executes after the handler, so its write is dropped.
  assign do_mtc0  = wr_hit && !take_int;

  always_comb begin
    rd_reg  = '0;
    rd_mask = '0;
    case (rd_addr)
      A_STATUS:  begin rd_reg = status_q & STATUS_MASK; rd_mask = STATUS_MASK; end
      A_CAUSE:   begin rd_reg = cause_val;              rd_mask = CAUSE_MASK;  end
      A_EPC:     begin rd_reg = epc_q;                  rd_mask = '1;          end
`ifdef CP0_TIMER_EN
      A_COUNT:   begin rd_reg = count_q;                rd_mask = '1;          end
      A_COMPARE: begin rd_reg = compare_q;              rd_mask = '1;          end
`endif
      default: ;
    endcase
  end

  // WB bypass: writable fields come from wb_wdata, read-only fields keep their
  // live value (which is 0 for Status/EPC, so this equals the masked write data).
  assign rd_data = (wr_hit && wb_addr == rd_addr) ? ((rd_reg & ~rd_mask) | (wb_wdata & rd_mask))
                                                  : rd_reg;

  always_comb begin
    case (cp0Forward)
      2'b01:   epc_out = ex_wdata;
      2'b10:   epc_out = mem_wdata;
      default: epc_out = (wr_hit && wb_addr == A_EPC) ? wb_wdata : epc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      ip_q       <= '0;
      sw_ip_q    <= '0;
      exc_code_q <= '0;
      exc_req    <= 1'b0;
      exc_pc     <= '0;
    end else begin
      ip_q    <= int_in;
      exc_req <= 1'b0;
      if (is_sys) begin
        // Nested trap keeps the outer EPC so the original return point survives.
        if (!status_q[1]) epc_q <= wb_pc;
        exc_code_q  <= 5'd8;
        status_q[1] <= 1'b1;
        exc_req     <= 1'b1;
        exc_pc      <= EXC_VECTOR;
      end else if (is_eret) begin
        status_q[1] <= 1'b0;
      end else if (take_int) begin
        epc_q       <= wb_pc;
        exc_code_q  <= 5'd0;
        status_q[1] <= 1'b1;
        exc_req     <= 1'b1;
        exc_pc      <= EXC_VECTOR;
      end else if (do_mtc0) begin
        case (wb_addr)
          A_STATUS: status_q <= wb_wdata & STATUS_MASK;
          A_CAUSE:  sw_ip_q  <= wb_wdata[9:8];
          A_EPC:    epc_q    <= wb_wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_EN
  // A Count write replaces the increment; the match is checked on the new value.
  assign count_nxt = (do_mtc0 && wb_addr == A_COUNT) ? wb_wdata : count_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q <= count_nxt;
      if (do_mtc0 && wb_addr == A_COMPARE) begin
        compare_q <= wb_wdata;
        ti_q      <= 1'b0;
      end else if (count_nxt == compare_q) begin
        ti_q <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile -- directed self-checking bench for cp0_regfile.
// Inputs change 1ns after the rising edge; outputs are sampled within the cycle.
module tb_cp0_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [2:0]  wb_cp0Op;
  logic [4:0]  wb_cs;
  logic [2:0]  wb_sel;
  logic [31:0] wb_wdata, wb_pc;
  logic [4:0]  rd_cs;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic [1:0]  cp0Forward;
  logic [31:0] ex_wdata, mem_wdata, epc_out;
  logic [5:0]  int_in;
  logic        exc_req;
  logic [31:0] exc_pc;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] v;

  cp0_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_cp0Op(wb_cp0Op), .wb_cs(wb_cs),
    .wb_sel(wb_sel), .wb_wdata(wb_wdata), .wb_pc(wb_pc), .rd_cs(rd_cs), .rd_sel(rd_sel),
    .rd_data(rd_data), .cp0Forward(cp0Forward), .ex_wdata(ex_wdata), .mem_wdata(mem_wdata),
    .epc_out(epc_out), .int_in(int_in), .exc_req(exc_req), .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_cp0Op = 3'b000; wb_cs = '0; wb_sel = '0; wb_wdata = '0; wb_pc = '0;
  endtask

  task automatic wb(input logic [2:0] op, input logic [4:0] cs, input logic [2:0] sel,
                    input logic [31:0] d, input logic [31:0] pc);
    wb_valid = 1'b1; wb_cp0Op = op; wb_cs = cs; wb_sel = sel; wb_wdata = d; wb_pc = pc;
  endtask

  task automatic rd(input logic [4:0] cs, input logic [2:0] sel, output logic [31:0] val);
    rd_cs = cs; rd_sel = sel;
    #1;
    val = rd_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); int_in = '0; cp0Forward = 2'b00; ex_wdata = '0; mem_wdata = '0;
    rd_cs = '0; rd_sel = '0;
    tick(); tick();
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL reset_exc_req got %b want 0", exc_req); end
    n_cmp++; if (exc_pc !== 32'h0) begin n_bad++; $display("FAIL reset_exc_pc got %h want 0", exc_pc); end
    rd(5'd12, 3'd0, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_status got %h want 0", v); end
    rd(5'd13, 3'd0, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_cause got %h want 0", v); end
    rd(5'd14, 3'd0, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_epc got %h want 0", v); end
    n_cmp++; if (epc_out !== 32'h0) begin n_bad++; $display("FAIL reset_epc_out got %h want 0", epc_out); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mtc0();
    wb(3'b010, 5'd14, 3'd0, 32'h0040_0100, 32'h0);
    rd(5'd14, 3'd0, v);
    n_cmp++; if (v !== 32'h0040_0100) begin n_bad++; $display("FAIL epc_bypass got %h want 00400100", v); end
    n_cmp++; if (epc_out !== 32'h0040_0100) begin n_bad++; $display("FAIL epc_out_bypass got %h want 00400100", epc_out); end
    tick(); idle();
    rd(5'd14, 3'd0, v);
    n_cmp++; if (v !== 32'h0040_0100) begin n_bad++; $display("FAIL epc_reg got %h want 00400100", v); end
    // Status write keeps only IM/EXL/IE.
    wb(3'b010, 5'd12, 3'd0, 32'hFFFF_FFFF, 32'h0);
    rd(5'd12, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_FF03) begin n_bad++; $display("FAIL status_bypass got %h want 0000ff03", v); end
    tick(); idle();
    rd(5'd12, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_FF03) begin n_bad++; $display("FAIL status_mask got %h want 0000ff03", v); end
    wb(3'b010, 5'd12, 3'd0, 32'h0, 32'h0); tick(); idle();
    // Cause write only touches soft IP.
    wb(3'b010, 5'd13, 3'd0, 32'hFFFF_FFFF, 32'h0); tick(); idle();
    rd(5'd13, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_0300) begin n_bad++; $display("FAIL cause_mask got %h want 00000300", v); end
    wb(3'b010, 5'd13, 3'd0, 32'h0, 32'h0); tick(); idle();
    // Unimplemented select: write dropped, EPC untouched.
    wb(3'b010, 5'd14, 3'd1, 32'hDEAD_BEEF, 32'h0); tick(); idle();
    rd(5'd14, 3'd1, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL unimpl_sel got %h want 0", v); end
    rd(5'd14, 3'd0, v);
    n_cmp++; if (v !== 32'h0040_0100) begin n_bad++; $display("FAIL epc_after_unimpl got %h want 00400100", v); end
  endtask

  task automatic test_syscall();
    wb(3'b011, 5'd0, 3'd0, 32'h0, 32'h0040_0020);
    #1;
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL sys_pre_req got %b want 0", exc_req); end
    tick(); idle();
    n_cmp++; if (exc_req !== 1'b1) begin n_bad++; $display("FAIL sys_req got %b want 1", exc_req); end
    n_cmp++; if (exc_pc !== 32'h0000_0800) begin n_bad++; $display("FAIL sys_pc got %h want 00000800", exc_pc); end
    rd(5'd14, 3'd0, v);
    n_cmp++; if (v !== 32'h0040_0020) begin n_bad++; $display("FAIL sys_epc got %h want 00400020", v); end
    rd(5'd13, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_0020) begin n_bad++; $display("FAIL sys_cause got %h want 00000020", v); end
    rd(5'd12, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_0002) begin n_bad++; $display("FAIL sys_exl got %h want 00000002", v); end
    tick();
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL sys_pulse got %b want 0", exc_req); end
    // Nested SYSCALL keeps EPC.
    wb(3'b011, 5'd0, 3'd0, 32'h0, 32'h0040_0040); tick(); idle();
    n_cmp++; if (exc_req !== 1'b1) begin n_bad++; $display("FAIL nest_req got %b want 1", exc_req); end
    rd(5'd14, 3'd0, v);
    n_cmp++; if (v !== 32'h0040_0020) begin n_bad++; $display("FAIL nest_epc got %h want 00400020", v); end
    tick();
    wb(3'b100, 5'd0, 3'd0, 32'h0, 32'h0); tick(); idle();
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL eret_req got %b want 0", exc_req); end
    rd(5'd12, 3'd0, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL eret_status got %h want 0", v); end
  endtask

  task automatic test_forward();
    ex_wdata = 32'hABCD_0000; mem_wdata = 32'h1234_5678;
    cp0Forward = 2'b01; #1;
    n_cmp++; if (epc_out !== 32'hABCD_0000) begin n_bad++; $display("FAIL fwd_ex got %h want abcd0000", epc_out); end
    cp0Forward = 2'b10; #1;
    n_cmp++; if (epc_out !== 32'h1234_5678) begin n_bad++; $display("FAIL fwd_mem got %h want 12345678", epc_out); end
    cp0Forward = 2'b00; #1;
    n_cmp++; if (epc_out !== 32'h0040_0020) begin n_bad++; $display("FAIL fwd_reg got %h want 00400020", epc_out); end
    cp0Forward = 2'b11; #1;
    n_cmp++; if (epc_out !== 32'h0040_0020) begin n_bad++; $display("FAIL fwd_sys got %h want 00400020", epc_out); end
    cp0Forward = 2'b00;
  endtask

  task automatic test_interrupt();
    wb(3'b010, 5'd12, 3'd0, 32'h0000_0401, 32'h0); tick(); idle();
    int_in = 6'b000001;
    tick(); tick();
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL int_no_wb got %b want 0", exc_req); end
    rd(5'd13, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_0420) begin n_bad++; $display("FAIL int_ip got %h want 00000420", v); end
    // Interrupt hits an MTC0 in WB: write is suppressed.
    wb(3'b010, 5'd14, 3'd0, 32'h0000_FFFF, 32'h0000_0100); tick(); idle();
    n_cmp++; if (exc_req !== 1'b1) begin n_bad++; $display("FAIL int_req got %b want 1", exc_req); end
    n_cmp++; if (exc_pc !== 32'h0000_0800) begin n_bad++; $display("FAIL int_pc got %h want 00000800", exc_pc); end
    rd(5'd14, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_0100) begin n_bad++; $display("FAIL int_epc got %h want 00000100", v); end
    rd(5'd13, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_0400) begin n_bad++; $display("FAIL int_cause got %h want 00000400", v); end
    rd(5'd12, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_0403) begin n_bad++; $display("FAIL int_status got %h want 00000403", v); end
    wb(3'b000, 5'd0, 3'd0, 32'h0, 32'h0000_0200); tick(); idle();
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL int_exl_block got %b want 0", exc_req); end
    rd(5'd14, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_0100) begin n_bad++; $display("FAIL int_exl_epc got %h want 00000100", v); end
    wb(3'b100, 5'd0, 3'd0, 32'h0, 32'h0); tick(); idle();
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL int_eret_req got %b want 0", exc_req); end
    rd(5'd12, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_0401) begin n_bad++; $display("FAIL int_eret_status got %h want 00000401", v); end
    int_in = '0;
    tick(); tick();
    wb(3'b010, 5'd12, 3'd0, 32'h0, 32'h0); tick(); idle();
  endtask

  task automatic test_back_to_back();
    wb(3'b011, 5'd0, 3'd0, 32'h0, 32'h0000_0300); tick();
    n_cmp++; if (exc_req !== 1'b1) begin n_bad++; $display("FAIL b2b_sys_req got %b want 1", exc_req); end
    wb(3'b100, 5'd0, 3'd0, 32'h0, 32'h0); tick(); idle();
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL b2b_eret_req got %b want 0", exc_req); end
    rd(5'd12, 3'd0, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL b2b_status got %h want 0", v); end
    rd(5'd14, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_0300) begin n_bad++; $display("FAIL b2b_epc got %h want 00000300", v); end
  endtask

  task automatic test_reset_mid();
    wb(3'b011, 5'd0, 3'd0, 32'h0, 32'h0000_0400); tick();
    n_cmp++; if (exc_req !== 1'b1) begin n_bad++; $display("FAIL rmid_req got %b want 1", exc_req); end
    rst_n = 1'b0;
    wb(3'b011, 5'd0, 3'd0, 32'h0, 32'h0000_0500); tick(); idle();
    n_cmp++; if (exc_req !== 1'b0) begin n_bad++; $display("FAIL rmid_clear got %b want 0", exc_req); end
    n_cmp++; if (exc_pc !== 32'h0) begin n_bad++; $display("FAIL rmid_pc got %h want 0", exc_pc); end
    rd(5'd14, 3'd0, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rmid_epc got %h want 0", v); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timer();
`ifdef CP0_TIMER_EN
    wb(3'b010, 5'd11, 3'd0, 32'd5, 32'h0); tick();
    wb(3'b010, 5'd9, 3'd0, 32'd0, 32'h0); tick(); idle();
    rd(5'd9, 3'd0, v);
    n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL tmr_count_load got %h want 0", v); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      rd(5'd13, 3'd0, v);
      n_cmp++; if (v[30] !== 1'b0) begin n_bad++; $display("FAIL tmr_ti_early got %b want 0 at count %0d", v[30], i); end
    end
    tick();
    rd(5'd13, 3'd0, v);
    n_cmp++; if ((v & 32'h4000_8000) !== 32'h4000_8000) begin n_bad++; $display("FAIL tmr_ti_set got %h want 40008000", v & 32'h4000_8000); end
    wb(3'b010, 5'd11, 3'd0, 32'h0000_1000, 32'h0); tick(); idle();
    rd(5'd13, 3'd0, v);
    n_cmp++; if (v[30] !== 1'b0) begin n_bad++; $display("FAIL tmr_ti_clear got %b want 0", v[30]); end
`else
    wb(3'b010, 5'd9, 3'd0, 32'h55, 32'h0); tick();
    wb(3'b010, 5'd11, 3'd0, 32'h66, 32'h0); tick(); idle();
    rd(5'd9, 3'd0, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL notmr_count got %h want 0", v); end
    rd(5'd11, 3'd0, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL notmr_compare got %h want 0", v); end
`endif
  endtask

  initial begin
    test_reset();
    test_mtc0();
    test_syscall();
    test_forward();
    test_interrupt();
    test_back_to_back();
    test_reset_mid();
    test_timer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
